bnn_inference_sequencer: RTL and testbench
==========================================

Name: bnn_inference_sequencer

Overview:
- Sequences one OCR inference from the SPI byte stream to the result.
- Accepts a load command and the packed binary image bytes, then writes them into the image buffer.
- Pulses the BNN core, waits for its class output with a timeout, and latches the result for result_out and SPI readback.
- Sits inside system_controller, between the SPI byte receiver and the image buffer / BNN datapath.

Parameters:
- IMG_BYTES, 128, image bytes per load (32x32 bits packed MSB-first).
- NUM_CLASSES, 10, legal class count; any infer_class >= NUM_CLASSES is an error.
- TIMEOUT_CYCLES, 4096, maximum cycles from infer_start to infer_done.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_byte holds a complete SPI byte.
- rx_byte  in  8  received byte.
- debug_trigger  in  1  level, already synchronous to clk; a rising edge requests a re-run.
- img_we  out  1  image buffer write enable.
- img_addr  out  $clog2(IMG_BYTES)  image buffer byte address.
- img_wdata  out  8  image buffer write data.
- infer_start  out  1  one-cycle start pulse to the BNN core.
- infer_done  in  1  one-cycle completion strobe from the core.
- infer_class  in  4  class index, valid only with infer_done.
- result_out  out  4  latched class; 4'hF on error.
- result_valid  out  1  result_out holds a valid class.
- tx_byte  out  8  status byte for CIPO: {result_valid, error, overrun, busy, result_out}.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - State IDLE.
  - img_we=0, img_addr=0, img_wdata=0, infer_start=0.
  - result_out=0, result_valid=0, busy=0.
  - error=0, overrun=0, loaded=0, timeout counter=0.
  - Edge-detector register=0.
  - All of the above apply on any cycle with rst=1, regardless of current state; no write or start is issued that cycle.
- Commands, decoded in IDLE only:
  - CMD_LOAD=8'hA5.
  - CMD_CLEAR=8'hC3: clears result_valid, error and overrun; result_out←0.
  - All other bytes in IDLE are ignored.
- IDLE:
  - rx_valid with CMD_LOAD → LOAD, byte counter←0, loaded←0, result_valid←0.
  - Else, a debug_trigger rising edge with loaded=1 → START. With loaded=0 the edge is ignored.
- LOAD:
  - Each rx_valid registers img_wdata←rx_byte and img_addr←counter, with img_we=1 for exactly the following cycle.
  - Write latency is 1 cycle from the rx_valid edge.
  - When the counter reaches IMG_BYTES-1 and rx_valid is high: loaded←1, next state START.
  - Command values received in LOAD are treated as data.
- START: infer_start=1 for exactly one cycle; timeout counter←0; → WAIT.
- WAIT:
  - Timeout counter increments each cycle.
  - infer_done with class < NUM_CLASSES: result_out←class, result_valid←1 → IDLE.
  - infer_done with class >= NUM_CLASSES: error←1, result_out←4'hF, result_valid←0 → IDLE.
  - Counter == TIMEOUT_CYCLES-1 without done: error←1, result_out←4'hF → IDLE.
  - infer_done and timeout in the same cycle: done wins.
- rx_valid in START or WAIT: byte dropped, overrun←1 (sticky until CMD_CLEAR).
- A debug_trigger edge outside IDLE is ignored; it is not queued.
- A stray infer_done outside WAIT is ignored.
- tx_byte is combinational from the registered flags and therefore reflects state with no extra latency.
- result_out holds its value until the next load, CMD_CLEAR, error, or reset.

Decomposition:
- Shared package bnn_pkg holds:
  - CMD_LOAD and CMD_CLEAR constants.
  - state_t enum {IDLE, LOAD, START, WAIT}.
  - Status bit positions for tx_byte.
  - NUM_CLASSES default.
- No sub-module. The edge detector and counters are inline.

Test Plan:
- Load and infer:
  - Stimulus: A5 then 128 bytes 0x00..0x7F; core returns infer_done with class 7 after 50 cycles.
  - Response: 128 writes with addr=data; one infer_start one cycle after the last write strobe; result_out=7, result_valid=1, tx_byte=8'h87.
- Timeout:
  - Stimulus: load, then never assert infer_done.
  - Response: after 4096 cycles in WAIT, state IDLE, error=1, result_out=4'hF, tx_byte=8'h4F.
- Invalid class, then clear:
  - Stimulus: infer_done with class 12, then send C3.
  - Response: error=1, result_out=F, result_valid=0; after C3, tx_byte=8'h00.
- Overrun and simultaneous events:
  - Stimulus: rx_valid during WAIT; infer_done with class 3 coinciding with the final timeout cycle.
  - Response: overrun=1, no image write; result_out=3, error=0.
- Re-run and gating:
  - Stimulus: debug_trigger rising edge after a completed load.
  - Response: new infer_start with no image writes.
  - Stimulus: the same edge before any load, or while busy.
  - Response: no infer_start.
- Reset mid-load:
  - Stimulus: rst asserted after 40 load bytes, then released.
  - Response: IDLE, no further writes, loaded=0, a subsequent debug_trigger edge is ignored, and a fresh A5 restarts at addr 0.

Source files
------------

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared commands, FSM states and status-byte layout for the BNN sequencer
package bnn_pkg;
  localparam logic [7:0] CMD_LOAD = 8'hA5;
  localparam logic [7:0] CMD_CLEAR = 8'hC3;
  localparam int NUM_CLASSES_DEF = 10;
  localparam int ST_VALID = 7;
  localparam int ST_ERROR = 6;
  localparam int ST_OVERRUN = 5;
  localparam int ST_BUSY = 4;
  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;
endpackage

// File: rtl/bnn_inference_sequencer.sv
// bnn_inference_sequencer: SPI image load, BNN start/wait with timeout, result latch
module bnn_inference_sequencer import bnn_pkg::*; #(
  parameter int IMG_BYTES = 128,
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_byte,
  input  logic                         debug_trigger,
  output logic                         img_we,
  output logic [$clog2(IMG_BYTES)-1:0] img_addr,
  output logic [7:0]                   img_wdata,
  output logic                         infer_start,
  input  logic                         infer_done,
  input  logic [3:0]                   infer_class,
  output logic [3:0]                   result_out,
  output logic                         result_valid,
  output logic [7:0]                   tx_byte,
  output logic                         busy
);
  localparam int AW = $clog2(IMG_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_t state, state_n;
  logic [AW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic we_q, start_q, error, overrun, loaded, trig_q;
  logic trig_rise, load_cmd, clear_cmd, last_byte, timeout, class_ok;
  // input decode shared by the FSM and the datapath
  always_comb begin
    trig_rise = debug_trigger & ~trig_q;
    load_cmd = rx_valid && rx_byte == CMD_LOAD;
    clear_cmd = rx_valid && rx_byte == CMD_CLEAR;
    last_byte = rx_valid && cnt == AW'(IMG_BYTES - 1);
    timeout = tcnt == TW'(TIMEOUT_CYCLES - 1);
    class_ok = int'(infer_class) < NUM_CLASSES;
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next-state logic; a done strobe outranks a coincident timeout
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = load_cmd ? LOAD : (trig_rise && loaded) ? START : IDLE;
      LOAD:  state_n = last_byte ? START : LOAD;
      START: state_n = WAIT;
      WAIT:  state_n = (infer_done || timeout) ? IDLE : WAIT;
    endcase
  end
  // outputs; strobes are suppressed while reset is held so nothing escapes that cycle
  always_comb begin
    busy = state != IDLE;
    img_we = we_q & ~rst;
    infer_start = start_q & ~rst;
    tx_byte = {4'h0, result_out};
    tx_byte[ST_VALID] = result_valid;
    tx_byte[ST_ERROR] = error;
    tx_byte[ST_OVERRUN] = overrun;
    tx_byte[ST_BUSY] = busy;
  end
  // datapath: write port, counters, sticky flags and result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tcnt <= '0;
      we_q <= 1'b0;
      start_q <= 1'b0;
      img_addr <= '0;
      img_wdata <= '0;
      result_out <= '0;
      result_valid <= 1'b0;
      error <= 1'b0;
      overrun <= 1'b0;
      loaded <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      trig_q <= debug_trigger;
      we_q <= state == LOAD && rx_valid;
      start_q <= state == START;
      tcnt <= state == START ? '0 : state == WAIT ? tcnt + 1'b1 : tcnt;
      if (state == IDLE && load_cmd) begin
        cnt <= '0;
        loaded <= 1'b0;
        result_valid <= 1'b0;
        result_out <= '0;
      end
      if (state == IDLE && clear_cmd) begin
        result_valid <= 1'b0;
        error <= 1'b0;
        overrun <= 1'b0;
        result_out <= '0;
      end
      if (state == LOAD && rx_valid) begin
        img_wdata <= rx_byte;
        img_addr <= cnt;
        cnt <= cnt + 1'b1;
        if (last_byte) loaded <= 1'b1;
      end
      if ((state == START || state == WAIT) && rx_valid) overrun <= 1'b1;
      if (state == WAIT && infer_done) begin
        result_out <= class_ok ? infer_class : 4'hF;
        result_valid <= class_ok;
        error <= error | ~class_ok;
      end else if (state == WAIT && timeout) begin
        result_out <= 4'hF;
        result_valid <= 1'b0;
        error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bnn_inference_sequencer.sv
// tb_bnn_inference_sequencer: directed and randomized checks against a flag/image model
module tb_bnn_inference_sequencer;
  logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, debug_trigger = 1'b0, infer_done = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [3:0] infer_class = 4'h0;
  logic img_we, infer_start, result_valid, busy;
  logic [6:0] img_addr;
  logic [7:0] img_wdata, tx_byte;
  logic [3:0] result_out;
  int errors = 0, checks = 0, cyc = 0, starts = 0, start_cyc = 0, last_we_cyc = 0;
  logic [7:0] mem [128];
  logic [7:0] img [128];
  logic [7:0] wa [$];
  logic [7:0] wd [$];
  logic m_valid = 1'b0, m_err = 1'b0, m_ovr = 1'b0;
  logic [3:0] m_res = 4'h0;

  bnn_inference_sequencer dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .debug_trigger(debug_trigger), .img_we(img_we), .img_addr(img_addr),
    .img_wdata(img_wdata), .infer_start(infer_start), .infer_done(infer_done),
    .infer_class(infer_class), .result_out(result_out), .result_valid(result_valid),
    .tx_byte(tx_byte), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (img_we) begin
      mem[img_addr] = img_wdata;
      wa.push_back({1'b0, img_addr});
      wd.push_back(img_wdata);
      last_we_cyc = cyc;
    end
    if (infer_start) begin
      starts++;
      start_cyc = cyc;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_tx(input logic b);
    return {m_valid, m_err, m_ovr, b, m_res};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_trig;
    debug_trigger = 1'b1;
    tick();
    debug_trigger = 1'b0;
  endtask

  task automatic load(input bit gaps);
    wa.delete();
    wd.delete();
    send(8'hA5);
    m_valid = 1'b0;
    m_res = 4'h0;
    for (int i = 0; i < 128; i++) begin
      send(img[i]);
      if (gaps && i < 127) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!infer_start && n < 20) begin
      tick();
      n++;
    end
    chk(tag, infer_start, 1);
  endtask

  task automatic finish_done(input string tag, input logic [3:0] c);
    infer_done = 1'b1;
    infer_class = c;
    tick();
    infer_done = 1'b0;
    if (c < 10) begin
      m_res = c;
      m_valid = 1'b1;
    end else begin
      m_res = 4'hF;
      m_valid = 1'b0;
      m_err = 1'b1;
    end
    chk({tag, "_res"}, result_out, m_res);
    chk({tag, "_valid"}, result_valid, m_valid);
    chk({tag, "_tx"}, tx_byte, exp_tx(1'b0));
  endtask

  task automatic check_image(input string tag);
    int bad = 0;
    for (int i = 0; i < 128; i++)
      if (i >= wa.size() || wa[i] != 8'(i) || wd[i] != img[i] || mem[i] != img[i]) bad++;
    chk({tag, "_nwr"}, wa.size(), 128);
    chk({tag, "_data"}, bad, 0);
    chk({tag, "_lat"}, start_cyc - last_we_cyc, 1);
  endtask

  task automatic clear;
    send(8'hC3);
    m_valid = 1'b0;
    m_err = 1'b0;
    m_ovr = 1'b0;
    m_res = 4'h0;
    chk("clear_tx", tx_byte, exp_tx(1'b0));
  endtask

  initial begin
    int n, s0, w0, lat;
    logic [7:0] b;
    logic [3:0] c;
    repeat (3) tick();
    chk("rst_we", img_we, 0);
    chk("rst_start", infer_start, 0);
    chk("rst_addr", img_addr, 0);
    chk("rst_tx", tx_byte, 8'h00);
    rst = 1'b0;
    tick();
    pulse_trig();
    repeat (10) tick();
    chk("trig_unloaded", starts, 0);
    chk("trig_unloaded_busy", busy, 0);
    infer_done = 1'b1;
    infer_class = 4'h5;
    tick();
    infer_done = 1'b0;
    chk("stray_done", tx_byte, exp_tx(1'b0));
    for (int i = 0; i < 128; i++) img[i] = 8'(i);
    load(1'b0);
    wait_start("seq_start");
    repeat (49) tick();
    finish_done("seq", 4'h7);
    chk("seq_tx87", tx_byte, 8'h87);
    check_image("seq");
    for (int r = 0; r < 3; r++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5 || b == 8'hC3) b ^= 8'h01;
      send(b);
      chk("junk_idle", tx_byte, exp_tx(1'b0));
      for (int i = 0; i < 128; i++) img[i] = 8'($urandom_range(0, 255));
      load(1'b1);
      wait_start("rnd_start");
      if ($urandom_range(0, 1) == 1) begin
        send(8'($urandom_range(0, 255)));
        m_ovr = 1'b1;
      end
      lat = $urandom_range(1, 300);
      repeat (lat) tick();
      c = 4'($urandom_range(0, 15));
      finish_done("rnd", c);
      check_image("rnd");
    end
    clear();
    s0 = starts;
    w0 = wa.size();
    pulse_trig();
    wait_start("bad_start");
    repeat (20) tick();
    finish_done("bad", 4'd12);
    chk("bad_tx", tx_byte, 8'h4F);
    chk("rerun_nowrite", wa.size(), w0);
    chk("rerun_one_start", starts - s0, 1);
    clear();
    chk("clear_00", tx_byte, 8'h00);
    pulse_trig();
    wait_start("tmo_start");
    n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, 4096);
    m_err = 1'b1;
    m_res = 4'hF;
    m_valid = 1'b0;
    chk("tmo_tx", tx_byte, 8'h4F);
    chk("tmo_res", result_out, 4'hF);
    clear();
    pulse_trig();
    wait_start("ovr_start");
    w0 = wa.size();
    send(8'h55);
    m_ovr = 1'b1;
    chk("ovr_flag", tx_byte[5], 1);
    repeat (4094) tick();
    chk("ovr_still_busy", busy, 1);
    finish_done("simul", 4'h3);
    chk("simul_err", tx_byte[6], 0);
    chk("simul_tx", tx_byte, 8'hA3);
    chk("ovr_nowrite", wa.size(), w0);
    clear();
    s0 = starts;
    pulse_trig();
    wait_start("busy_start");
    pulse_trig();
    repeat (5) tick();
    finish_done("busy", 4'h2);
    repeat (10) tick();
    chk("busy_trig_ignored", starts - s0, 1);
    wa.delete();
    wd.delete();
    send(8'hA5);
    for (int i = 0; i < 40; i++) send(8'($urandom_range(0, 255)));
    tick();
    chk("midload_writes", wa.size(), 40);
    rst = 1'b1;
    tick();
    chk("midrst_we", img_we, 0);
    tick();
    rst = 1'b0;
    m_valid = 1'b0;
    m_err = 1'b0;
    m_ovr = 1'b0;
    m_res = 4'h0;
    chk("midrst_tx", tx_byte, 8'h00);
    repeat (5) tick();
    s0 = starts;
    pulse_trig();
    repeat (10) tick();
    chk("midrst_trig_ignored", starts - s0, 0);
    chk("midrst_nowrite", wa.size(), 40);
    for (int i = 0; i < 128; i++) img[i] = 8'($urandom_range(0, 255));
    load(1'b1);
    wait_start("reload_start");
    repeat (10) tick();
    finish_done("reload", 4'h9);
    check_image("reload");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
